// File: rtl/dcache_arb_pkg.sv
// Shared constants and tag helpers for the dcache request/response arbiter.
package dcache_arb_pkg;
  localparam int   TAG_W        = 5;
  localparam int   ID_W         = 4;
  localparam logic OWN_LSQ      = 1'b0;
  localparam logic OWN_AUX      = 1'b1;
  localparam int   OP_STORE_BIT = 0;

  typedef struct packed {
    logic            owner;
    logic [ID_W-1:0] id;
  } dc_tag_t;

  function automatic logic [TAG_W-1:0] make_tag(input logic owner, input logic [ID_W-1:0] id);
    return {owner, id};
  endfunction
endpackage

// File: rtl/lsqid_tracker.sv
// Per-load-id outstanding (pend) and flushed-epoch (stale) bookkeeping.
module lsqid_tracker
  import dcache_arb_pkg::*;
#(
  parameter int NUM_LSQID = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ID_W-1:0]      set_id,
  input  logic                 flush,
  input  logic                 clr_en,
  input  logic [ID_W-1:0]      clr_id,
  output logic [NUM_LSQID-1:0] pend,
  output logic [NUM_LSQID-1:0] stale
);

  logic [NUM_LSQID-1:0] pend_n;
  logic [NUM_LSQID-1:0] stale_n;

  // Order matters: response clear, then flush marks survivors, then a new beat.
  always_comb begin
    pend_n  = pend;
    stale_n = stale;
    if (clr_en) begin
      pend_n[clr_id]  = 1'b0;
      stale_n[clr_id] = 1'b0;
    end
    if (flush) stale_n = stale_n | pend_n;
    if (set_en) begin
      pend_n[set_id]  = 1'b1;
      stale_n[set_id] = flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      stale <= '0;
    end else begin
      pend  <= pend_n;
      stale <= stale_n;
    end
  end

endmodule

// File: rtl/dcache_arb.sv
// Arbitrates the dcache request port between the LSQ and one auxiliary
// requester, tags requests with their owner and routes responses back.
module dcache_arb
  import dcache_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int NUM_LSQID  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsq_dc_req,
  input  logic [3:0]       lsq_dc_op,
  input  logic [31:0]      lsq_dc_addr,
  input  logic [ID_W-1:0]  lsq_dc_lsqid,
  input  logic [31:0]      lsq_dc_wdata,
  input  logic             lsq_dc_flush,
  output logic             arb_lsq_ready,
  input  logic             aux_req,
  input  logic [3:0]       aux_op,
  input  logic [31:0]      aux_addr,
  input  logic [31:0]      aux_wdata,
  output logic             arb_aux_ready,
  output logic             dc_req,
  output logic [3:0]       dc_op,
  output logic [31:0]      dc_addr,
  output logic [31:0]      dc_wdata,
  output logic [TAG_W-1:0] dc_tag,
  output logic             dc_flush,
  input  logic             dcache_ready,
  input  logic             dcache_valid,
  input  logic             dcache_error,
  input  logic [TAG_W-1:0] dcache_tag,
  input  logic [31:0]      dcache_rdata,
  output logic             arb_lsq_valid,
  output logic             arb_lsq_error,
  output logic [ID_W-1:0]  arb_lsq_lsqid,
  output logic [31:0]      arb_lsq_rdata,
  output logic             arb_aux_valid,
  output logic             arb_aux_error,
  output logic [31:0]      arb_aux_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [NUM_LSQID-1:0] pend;
  logic [NUM_LSQID-1:0] stale;
  logic [CNT_W-1:0]     starve_cnt;
  logic                 aux_busy;

  // Inputs are masked while rst is high so every output reads 0 in reset.
  logic lsq_req_m, aux_req_m, rdy_m, rsp_vld_m, flush_m;
  assign lsq_req_m = lsq_dc_req   & ~rst;
  assign aux_req_m = aux_req      & ~rst;
  assign rdy_m     = dcache_ready & ~rst;
  assign rsp_vld_m = dcache_valid & ~rst;
  assign flush_m   = lsq_dc_flush & ~rst;

  dc_tag_t rsp_tag;
  assign rsp_tag = dcache_tag;

  logic lsq_is_load, lsq_elig, aux_elig, aux_win, lsq_win;
  assign lsq_is_load = ~lsq_dc_op[OP_STORE_BIT];
  assign lsq_elig    = lsq_req_m & ~(lsq_is_load & pend[lsq_dc_lsqid] & stale[lsq_dc_lsqid]);
  assign aux_elig    = aux_req_m & ~aux_busy;
  assign aux_win     = aux_elig & (~lsq_elig | (starve_cnt == STARVE_LIM));
  assign lsq_win     = lsq_elig & ~aux_win;

  assign arb_lsq_ready = rdy_m & lsq_win;
  assign arb_aux_ready = rdy_m & aux_win;
  assign dc_req        = lsq_win | aux_win;
  assign dc_flush      = flush_m;

  always_comb begin
    dc_op    = '0;
    dc_addr  = '0;
    dc_wdata = '0;
    dc_tag   = '0;
    if (aux_win) begin
      dc_op    = aux_op;
      dc_addr  = aux_addr;
      dc_wdata = aux_wdata;
      dc_tag   = make_tag(OWN_AUX, '0);
    end else if (lsq_win) begin
      dc_op    = lsq_dc_op;
      dc_addr  = lsq_dc_addr;
      dc_wdata = lsq_dc_wdata;
      dc_tag   = make_tag(OWN_LSQ, lsq_dc_lsqid);
    end
  end

  logic lsq_rsp, aux_rsp;
  assign lsq_rsp = rsp_vld_m & (rsp_tag.owner == OWN_LSQ);
  assign aux_rsp = rsp_vld_m & (rsp_tag.owner == OWN_AUX);

  lsqid_tracker #(.NUM_LSQID(NUM_LSQID)) u_trk (
    .clk    (clk),
    .rst    (rst),
    .set_en (arb_lsq_ready & lsq_is_load),
    .set_id (lsq_dc_lsqid),
    .flush  (flush_m),
    .clr_en (lsq_rsp),
    .clr_id (rsp_tag.id),
    .pend   (pend),
    .stale  (stale)
  );

  assign arb_lsq_valid = lsq_rsp & ~stale[rsp_tag.id] & ~flush_m;
  assign arb_lsq_error = dcache_error & ~rst;
  assign arb_lsq_lsqid = rsp_tag.id & {ID_W{~rst}};
  assign arb_lsq_rdata = dcache_rdata & {32{~rst}};
  assign arb_aux_valid = aux_rsp;
  assign arb_aux_error = dcache_error & ~rst;
  assign arb_aux_rdata = dcache_rdata & {32{~rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      aux_busy   <= 1'b0;
    end else begin
      if (!aux_elig || arb_aux_ready) starve_cnt <= '0;
      else if (arb_lsq_ready && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
      // A new aux beat outranks a same-cycle aux response.
      if (arb_aux_ready) aux_busy <= 1'b1;
      else if (aux_rsp)  aux_busy <= 1'b0;
    end
  end

  a_known_rsp: assert property (@(posedge clk) disable iff (rst) lsq_rsp |-> pend[rsp_tag.id]);

endmodule

// File: tb/tb_dcache_arb.sv
// Scoreboard bench for dcache_arb: grant tags and routed responses are queued as expected and popped on observation.
module tb_dcache_arb;
  import dcache_arb_pkg::*;

  typedef struct packed {
    logic        lsq_v;
    logic        aux_v;
    logic [31:0] data;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsq_dc_req, lsq_dc_flush, aux_req, dcache_ready, dcache_valid, dcache_error;
  logic [3:0]  lsq_dc_op, lsq_dc_lsqid, aux_op;
  logic [31:0] lsq_dc_addr, lsq_dc_wdata, aux_addr, aux_wdata, dcache_rdata;
  logic [4:0]  dcache_tag;
  logic        arb_lsq_ready, arb_aux_ready, dc_req, dc_flush;
  logic [3:0]  dc_op, arb_lsq_lsqid;
  logic [31:0] dc_addr, dc_wdata, arb_lsq_rdata, arb_aux_rdata;
  logic [4:0]  dc_tag;
  logic        arb_lsq_valid, arb_lsq_error, arb_aux_valid, arb_aux_error;
  logic [148:0] outs;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] grant_q[$];
  rsp_exp_t   resp_q[$];

  dcache_arb #(.STARVE_MAX(4), .NUM_LSQID(16)) dut (
    .clk(clk), .rst(rst),
    .lsq_dc_req(lsq_dc_req), .lsq_dc_op(lsq_dc_op), .lsq_dc_addr(lsq_dc_addr),
    .lsq_dc_lsqid(lsq_dc_lsqid), .lsq_dc_wdata(lsq_dc_wdata), .lsq_dc_flush(lsq_dc_flush),
    .arb_lsq_ready(arb_lsq_ready),
    .aux_req(aux_req), .aux_op(aux_op), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .arb_aux_ready(arb_aux_ready),
    .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_tag(dc_tag),
    .dc_flush(dc_flush), .dcache_ready(dcache_ready),
    .dcache_valid(dcache_valid), .dcache_error(dcache_error), .dcache_tag(dcache_tag),
    .dcache_rdata(dcache_rdata),
    .arb_lsq_valid(arb_lsq_valid), .arb_lsq_error(arb_lsq_error), .arb_lsq_lsqid(arb_lsq_lsqid),
    .arb_lsq_rdata(arb_lsq_rdata),
    .arb_aux_valid(arb_aux_valid), .arb_aux_error(arb_aux_error), .arb_aux_rdata(arb_aux_rdata)
  );

  always #5 clk = ~clk;

  assign outs = {dc_req, dc_op, dc_addr, dc_wdata, dc_tag, dc_flush, arb_lsq_ready, arb_aux_ready,
                 arb_lsq_valid, arb_lsq_error, arb_lsq_lsqid, arb_lsq_rdata,
                 arb_aux_valid, arb_aux_error, arb_aux_rdata};

  task automatic idle();
    lsq_dc_req = 0; lsq_dc_op = 0; lsq_dc_addr = 0; lsq_dc_lsqid = 0; lsq_dc_wdata = 0;
    lsq_dc_flush = 0; aux_req = 0; aux_op = 0; aux_addr = 0; aux_wdata = 0;
    dcache_ready = 1; dcache_valid = 0; dcache_error = 0; dcache_tag = 0; dcache_rdata = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic lsq_load(input logic [3:0] id, input logic [31:0] addr);
    lsq_dc_req = 1; lsq_dc_op = 4'h0; lsq_dc_lsqid = id; lsq_dc_addr = addr;
  endtask

  task automatic rsp(input logic [4:0] tag, input logic [31:0] data);
    dcache_valid = 1; dcache_tag = tag; dcache_rdata = data;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    lsq_load(4'h3, 32'h100); aux_req = 1; lsq_dc_flush = 1; rsp(5'h03, 32'hFFFF_FFFF);
    #2;
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", outs); end
    cyc();
    n_cmp++; if (dut.u_trk.pend !== 16'h0) begin n_bad++; $display("FAIL reset_pend: got %h want 0", dut.u_trk.pend); end
    idle();
    rst = 0;
    cyc();
  endtask

  task automatic test_basic_load();
    logic [4:0] e; rsp_exp_t x;
    grant_q.push_back(make_tag(OWN_LSQ, 4'h3));
    lsq_load(4'h3, 32'h100);
    #1;
    e = grant_q.pop_front();
    n_cmp++; if (dc_tag !== e || dc_req !== 1'b1 || arb_lsq_ready !== 1'b1 || dc_addr !== 32'h100) begin
      n_bad++; $display("FAIL basic_grant: got tag %h req %b rdy %b addr %h want tag %h", dc_tag, dc_req, arb_lsq_ready, dc_addr, e);
    end
    cyc();
    lsq_dc_req = 0;
    n_cmp++; if (dut.u_trk.pend[3] !== 1'b1) begin n_bad++; $display("FAIL basic_pend3: got %b want 1", dut.u_trk.pend[3]); end
    resp_q.push_back('{lsq_v: 1'b1, aux_v: 1'b0, data: 32'hDEAD_BEEF});
    rsp(5'h03, 32'hDEAD_BEEF);
    #1;
    x = resp_q.pop_front();
    n_cmp++; if ({arb_lsq_valid, arb_aux_valid, arb_lsq_rdata, arb_lsq_lsqid} !== {x.lsq_v, x.aux_v, x.data, 4'h3}) begin
      n_bad++; $display("FAIL basic_rsp: got v %b/%b data %h id %h want %b/%b %h 3", arb_lsq_valid, arb_aux_valid, arb_lsq_rdata, arb_lsq_lsqid, x.lsq_v, x.aux_v, x.data);
    end
    cyc();
    idle();
    n_cmp++; if (dut.u_trk.pend[3] !== 1'b0) begin n_bad++; $display("FAIL basic_pend3_clr: got %b want 0", dut.u_trk.pend[3]); end
  endtask

  task automatic test_starvation();
    logic [4:0] e; rsp_exp_t x;
    for (int i = 0; i < 4; i++) grant_q.push_back(make_tag(OWN_LSQ, 4'(i)));
    grant_q.push_back(5'h10);
    aux_req = 1; aux_op = 4'h2; aux_addr = 32'h2000;
    for (int i = 0; i < 5; i++) begin
      lsq_dc_req = 1; lsq_dc_op = 4'h1; lsq_dc_lsqid = 4'(i); lsq_dc_addr = 32'h300 + 32'(i * 4);
      #1;
      e = grant_q.pop_front();
      n_cmp++; if (dc_req !== 1'b1 || dc_tag !== e) begin n_bad++; $display("FAIL starve_tag%0d: got %h want %h", i, dc_tag, e); end
      n_cmp++; if ({arb_lsq_ready, arb_aux_ready} !== (e[4] ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL starve_rdy%0d: got %b%b want owner %b", i, arb_lsq_ready, arb_aux_ready, e[4]);
      end
      if (i == 4) begin
        n_cmp++; if (dut.starve_cnt !== 3'd4) begin n_bad++; $display("FAIL starve_cnt_sat: got %0d want 4", dut.starve_cnt); end
      end
      cyc();
    end
    n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_bad++; $display("FAIL starve_cnt_clr: got %0d want 0", dut.starve_cnt); end
    n_cmp++; if ({arb_lsq_ready, arb_aux_ready} !== 2'b10) begin n_bad++; $display("FAIL starve_busy: got %b%b want 10", arb_lsq_ready, arb_aux_ready); end
    n_cmp++; if (dut.u_trk.pend !== 16'h0) begin n_bad++; $display("FAIL store_untracked: got %h want 0", dut.u_trk.pend); end
    idle();
    resp_q.push_back('{lsq_v: 1'b0, aux_v: 1'b1, data: 32'hA5A5_0001});
    rsp(5'h10, 32'hA5A5_0001);
    #1;
    x = resp_q.pop_front();
    n_cmp++; if ({arb_lsq_valid, arb_aux_valid, arb_aux_rdata} !== {x.lsq_v, x.aux_v, x.data}) begin
      n_bad++; $display("FAIL starve_aux_rsp: got %b/%b %h want %b/%b %h", arb_lsq_valid, arb_aux_valid, arb_aux_rdata, x.lsq_v, x.aux_v, x.data);
    end
    cyc();
    idle();
  endtask

  task automatic test_flush_stale();
    rsp_exp_t x;
    lsq_load(4'h5, 32'h500);
    #1;
    n_cmp++; if (arb_lsq_ready !== 1'b1) begin n_bad++; $display("FAIL flush_issue5: got %b want 1", arb_lsq_ready); end
    cyc();
    lsq_dc_req = 0; lsq_dc_flush = 1;
    #1;
    n_cmp++; if (dc_flush !== 1'b1) begin n_bad++; $display("FAIL flush_copy: got %b want 1", dc_flush); end
    cyc();
    lsq_dc_flush = 0;
    n_cmp++; if (dut.u_trk.stale[5] !== 1'b1) begin n_bad++; $display("FAIL flush_stale5: got %b want 1", dut.u_trk.stale[5]); end
    lsq_load(4'h5, 32'h540);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if ({arb_lsq_ready, dc_req} !== 2'b00) begin n_bad++; $display("FAIL flush_block%0d: got %b%b want 00", i, arb_lsq_ready, dc_req); end
      cyc();
    end
    resp_q.push_back('{lsq_v: 1'b0, aux_v: 1'b0, data: 32'h0000_0055});
    rsp(5'h05, 32'h0000_0055);
    #1;
    x = resp_q.pop_front();
    n_cmp++; if ({arb_lsq_valid, arb_aux_valid, arb_lsq_ready} !== {x.lsq_v, x.aux_v, 1'b0}) begin
      n_bad++; $display("FAIL flush_squash: got v %b/%b rdy %b want %b/%b 0", arb_lsq_valid, arb_aux_valid, arb_lsq_ready, x.lsq_v, x.aux_v);
    end
    cyc();
    dcache_valid = 0;
    #1;
    n_cmp++; if (arb_lsq_ready !== 1'b1 || dc_tag !== 5'h05) begin n_bad++; $display("FAIL flush_reissue: got %b tag %h want 1 05", arb_lsq_ready, dc_tag); end
    cyc();
    lsq_dc_req = 0;
    resp_q.push_back('{lsq_v: 1'b1, aux_v: 1'b0, data: 32'h0000_5555});
    rsp(5'h05, 32'h0000_5555);
    #1;
    x = resp_q.pop_front();
    n_cmp++; if ({arb_lsq_valid, arb_lsq_rdata} !== {x.lsq_v, x.data}) begin
      n_bad++; $display("FAIL flush_new_rsp: got %b %h want %b %h", arb_lsq_valid, arb_lsq_rdata, x.lsq_v, x.data);
    end
    cyc();
    idle();
  endtask

  task automatic test_same_cycle_flush();
    rsp_exp_t x;
    lsq_load(4'h2, 32'h200); lsq_dc_flush = 1;
    #1;
    n_cmp++; if (arb_lsq_ready !== 1'b1) begin n_bad++; $display("FAIL sameflush_issue: got %b want 1", arb_lsq_ready); end
    cyc();
    idle();
    n_cmp++; if ({dut.u_trk.pend[2], dut.u_trk.stale[2]} !== 2'b11) begin
      n_bad++; $display("FAIL sameflush_state: got %b%b want 11", dut.u_trk.pend[2], dut.u_trk.stale[2]);
    end
    resp_q.push_back('{lsq_v: 1'b0, aux_v: 1'b0, data: 32'h0000_0022});
    rsp(5'h02, 32'h0000_0022);
    #1;
    x = resp_q.pop_front();
    n_cmp++; if ({arb_lsq_valid, arb_aux_valid, arb_lsq_rdata} !== {x.lsq_v, x.aux_v, x.data}) begin
      n_bad++; $display("FAIL sameflush_drop: got %b/%b %h want %b/%b %h", arb_lsq_valid, arb_aux_valid, arb_lsq_rdata, x.lsq_v, x.aux_v, x.data);
    end
    cyc();
    idle();
  endtask

  task automatic test_aux_busy();
    logic [4:0] e; rsp_exp_t x;
    grant_q.push_back(5'h10);
    aux_req = 1; aux_op = 4'h1; aux_addr = 32'h4000; aux_wdata = 32'h1111;
    #1;
    e = grant_q.pop_front();
    n_cmp++; if (arb_aux_ready !== 1'b1 || dc_tag !== e || dc_addr !== 32'h4000) begin
      n_bad++; $display("FAIL aux_grant: got %b tag %h addr %h want 1 %h 4000", arb_aux_ready, dc_tag, dc_addr, e);
    end
    cyc();
    aux_addr = 32'h4004;
    #1;
    n_cmp++; if ({arb_aux_ready, dc_req} !== 2'b00) begin n_bad++; $display("FAIL aux_blocked: got %b%b want 00", arb_aux_ready, dc_req); end
    lsq_dc_flush = 1;
    cyc();
    lsq_dc_flush = 0;
    resp_q.push_back('{lsq_v: 1'b0, aux_v: 1'b1, data: 32'hCAFE_0001});
    rsp(5'h10, 32'hCAFE_0001);
    #1;
    x = resp_q.pop_front();
    n_cmp++; if ({arb_lsq_valid, arb_aux_valid, arb_aux_rdata, arb_aux_ready} !== {x.lsq_v, x.aux_v, x.data, 1'b0}) begin
      n_bad++; $display("FAIL aux_rsp_after_flush: got %b/%b %h rdy %b want %b/%b %h 0", arb_lsq_valid, arb_aux_valid, arb_aux_rdata, arb_aux_ready, x.lsq_v, x.aux_v, x.data);
    end
    cyc();
    dcache_valid = 0;
    #1;
    n_cmp++; if (arb_aux_ready !== 1'b1 || dc_addr !== 32'h4004) begin n_bad++; $display("FAIL aux_regrant: got %b %h want 1 4004", arb_aux_ready, dc_addr); end
    cyc();
    idle();
    rsp(5'h10, 32'h0);
    cyc();
    idle();
  endtask

  task automatic test_rst_mid();
    for (int i = 7; i < 10; i++) begin
      lsq_load(4'(i), 32'h700 + 32'(i));
      cyc();
    end
    idle();
    n_cmp++; if (dut.u_trk.pend !== 16'h0380) begin n_bad++; $display("FAIL rst_pend_before: got %h want 0380", dut.u_trk.pend); end
    rst = 1;
    lsq_load(4'h1, 32'h10); aux_req = 1; rsp(5'h07, 32'h1234_5678); dcache_error = 1;
    #1;
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL rst_mid_outs: got %h want 0", outs); end
    cyc();
    rst = 0;
    idle();
    #1;
    n_cmp++; if ({dut.u_trk.pend, dut.u_trk.stale} !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_state: got %h %h want 0 0", dut.u_trk.pend, dut.u_trk.stale);
    end
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL rst_release_outs: got %h want 0", outs); end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_starvation();
    test_flush_stale();
    test_same_cycle_flush();
    test_aux_busy();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_arb.md
# dcache_arb

Shares the single data-cache request port between the load-store queue and one auxiliary requester, such as a page-table walker or debug access port. Requests are granted combinationally with a starvation guard, and every request is tagged with its owner. Responses are routed back to whoever issued them. Load responses that belong to a pipeline flush epoch already discarded are squashed before they reach the LSQ. The block sits between the LSQ/aux ports and the dcache.

## Interface
- `STARVE_MAX`, default 4: consecutive denied cycles of a pending aux request after which aux gets priority.
- `NUM_LSQID`, default 16: number of LSQ load ids tracked; id width is 4.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `lsq_dc_req` in 1: LSQ request valid.
- `lsq_dc_op` in 4: op; bit0=1 store, bit0=0 load, [3:1] type.
- `lsq_dc_addr` in 32: byte address.
- `lsq_dc_lsqid` in 4: load id.
- `lsq_dc_wdata` in 32: store data.
- `lsq_dc_flush` in 1: pipeline flush.
- `arb_lsq_ready` out 1: LSQ request accepted this cycle.
- `aux_req`, `aux_op`, `aux_addr`, `aux_wdata` in 1/4/32/32: aux request.
- `arb_aux_ready` out 1: aux request accepted.
- `dc_req` out 1, `dc_op` out 4, `dc_addr` out 32, `dc_wdata` out 32, `dc_tag` out 5: request to the dcache. `dc_tag` = {owner, id}; owner 0 = LSQ, 1 = aux; aux id = 0.
- `dc_flush` out 1: copy of `lsq_dc_flush`.
- `dcache_ready` in 1: dcache accepts `dc_req`.
- `dcache_valid` in 1, `dcache_error` in 1, `dcache_tag` in 5, `dcache_rdata` in 32: response.
- `arb_lsq_valid`, `arb_lsq_error`, `arb_lsq_lsqid`[4], `arb_lsq_rdata`[32] out: routed LSQ response.
- `arb_aux_valid`, `arb_aux_error`, `arb_aux_rdata`[32] out: routed aux response.

## Operation
- **Eligibility.**
  - The LSQ is eligible when `lsq_dc_req` is high, except for a load whose id has `pend[id] & stale[id]`.
  - Aux is eligible when `aux_req & ~aux_busy`.
- **Priority.**
  - The LSQ wins by default.
  - Aux wins when `starve_cnt == STARVE_MAX`.
- **Beat and readies.**
  - beat = `dcache_ready` & a winner exists.
  - `arb_*_ready` goes high only for the winner on a beat.
  - The `dc_*` outputs mux the winner's fields and are combinational.
- **starve_cnt.**
  - Increments, saturating at `STARVE_MAX`, when aux is eligible but loses to the LSQ on a beat.
  - Clears on an aux beat, or in any cycle aux is not eligible.
- **LSQ load beat.**
  - Sets `pend[id]`.
  - Sets `stale[id]` if `lsq_dc_flush` is high in the same cycle.
  - Otherwise clears `stale[id]`.
  - Stores are untracked: they produce no response.
- **Flush.** `stale |= pend` (including the same-cycle beat, above).
- **LSQ response** (`dcache_tag[4]` = 0).
  - Clears `pend[id]` and `stale[id]`.
  - `arb_lsq_valid = dcache_valid & ~stale[id] & ~lsq_dc_flush`.
- **Aux response** (`dcache_tag[4]` = 1).
  - Clears `aux_busy`; `arb_aux_valid` = `dcache_valid`.
  - An aux beat sets `aux_busy`; flush does not affect aux.
- **Data fields.** The data and error outputs are pass-through of the dcache response fields, whatever the valid bits.
- **Unknown responses.** A response to an id with `pend=0` is an assertion failure in simulation.

## Timing
- Request path: zero latency; grant is combinational in the same cycle.
- Response routing: zero latency.
- **State updates** at the `clk` edge:
  - `pend`, `stale`, `aux_busy` and `starve_cnt` update at the edge.
  - Set and clear of the same `pend` bit in one cycle cannot occur, because the id is blocked or not reissued.
- **Reset.**
  - All state resets to 0.
  - Every output is 0 in reset, since inputs are masked while `rst` is high.
  - Asserting `rst` mid-operation drops all tracking.
- **Same-cycle aux response and aux beat.** The clear happens first, so `aux_busy` ends at 1.

## Structure
- Package `dcache_arb_pkg` holds:
  - owner encoding: `OWN_LSQ` = 0, `OWN_AUX` = 1;
  - `OP_STORE_BIT` = 0;
  - tag width 5.
- One sub-module, `lsqid_tracker`, owns the `pend`/`stale` vectors and the flush/set/clear logic.
- The arbitration and starvation logic stays in the top module.

## Test plan
- LSQ load id 3 at addr 0x100 with aux idle → `dc_tag`=0x03 and `pend[3]`=1. The response with tag 0x03 and data 0xDEADBEEF → `arb_lsq_valid`=1 and `arb_lsq_rdata`=0xDEADBEEF.
- LSQ requesting every cycle, aux requesting, `STARVE_MAX`=4, `dcache_ready` always high:
  - the LSQ is granted 4 beats;
  - on the 5th beat aux is granted with `dc_tag`=0x10;
  - `starve_cnt` returns to 0.
- Load id 5 outstanding, then flush → a later response with tag 0x05 gives `arb_lsq_valid`=0. A new load to id 5 before that response → `arb_lsq_ready`=0 until the response arrives.
- Load beat id 2 in the same cycle as flush → `stale[2]`=1 and its response is dropped.
- Aux beat then second aux request → `arb_aux_ready`=0 until the aux response arrives. A flush in between does not drop the aux response.
- `rst` asserted with 3 loads pending → after release `pend`=0 and all outputs are 0.
